// File: rtl/lc3_pkg.sv
// lc3_pkg: shared opcodes, error codes and FSM states for the LC-3 transaction checker.
package lc3_pkg;
  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RES  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;
  typedef enum logic [2:0] {
    ERR_NONE, ERR_ADDR, ERR_DATA, ERR_DIR, ERR_TIMEOUT, ERR_OVERLAP, ERR_ILLEGAL
  } err_e;
  typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2, S_REPORT} state_e;
endpackage

// File: rtl/lc3_access_plan.sv
// lc3_access_plan: opcode to expected memory-access plan (count, per-access direction, illegal).
module lc3_access_plan
  import lc3_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [1:0] n_acc,
  output logic       dir1,
  output logic       dir2,
  output logic       illegal
);
  // JMP/JSR count as one read: the fetch at the branch target
  assign n_acc   = (opcode inside {OP_LDI, OP_STI}) ? 2'd2 :
                   (opcode inside {OP_LD, OP_LDR, OP_ST, OP_STR, OP_JMP, OP_JSR}) ? 2'd1 : 2'd0;
  assign dir1    = opcode inside {OP_ST, OP_STR};
  assign dir2    = opcode == OP_STI;
  assign illegal = opcode inside {OP_RTI, OP_RES, OP_TRAP};
endmodule

// File: rtl/lc3_txn_checker.sv
// lc3_txn_checker: checks each LC-3 instruction's memory accesses against golden values.
module lc3_txn_checker
  import lc3_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instr,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] addr_ideal,
  input  logic [DATA_W-1:0] data_ideal,
  output logic              busy,
  output logic              chk_done,
  output logic              chk_pass,
  output logic [3:0]        chk_opcode,
  output logic [2:0]        err_code,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_e state, state_n;
  err_e rep_err, acc_err;
  logic [3:0] cur_op, rep_op;
  logic [1:0] cur_n, p_n;
  logic cur_d1, cur_d2, p_d1, p_d2, p_ill;
  logic [TW-1:0] tmo, tmo_n;
  logic pend_v, pend_v_n;
  logic [DATA_W-1:0] pend_i, pend_i_n, st_instr;
  logic start, load, rep, rep_pass, lost, exp_dir, last;
  logic [CNT_W:0] psum, fsum;
  // a pending instruction only exists while in REPORT; a fresh pulse overrides it
  assign start    = instr_valid || pend_v;
  assign st_instr = instr_valid ? instr : pend_i;
  assign exp_dir  = (state == S_ACC1) ? cur_d1 : cur_d2;
  assign last     = (state == S_ACC2) || (cur_n == 2'd1);
  assign acc_err  = (mem_we != exp_dir) ? ERR_DIR :
                    (mem_addr != addr_ideal) ? ERR_ADDR :
                    (mem_we && mem_wdata != data_ideal) ? ERR_DATA : ERR_NONE;
  assign rep      = state_n == S_REPORT;
  assign psum     = {1'b0, pass_cnt} + (CNT_W+1)'(rep && rep_pass);
  assign fsum     = {1'b0, fail_cnt} + (CNT_W+1)'(rep && !rep_pass) + (CNT_W+1)'(lost);

  lc3_access_plan u_plan (
    .opcode (st_instr[DATA_W-1 -: 4]),
    .n_acc  (p_n),
    .dir1   (p_d1),
    .dir2   (p_d2),
    .illegal(p_ill)
  );

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    rep_pass = 1'b0;
    rep_err  = ERR_NONE;
    rep_op   = cur_op;
    tmo_n    = tmo;
    pend_v_n = pend_v;
    pend_i_n = pend_i;
    lost     = 1'b0;
    case (state)
      S_IDLE, S_REPORT: begin
        state_n  = S_IDLE;
        pend_v_n = 1'b0;
        lost     = instr_valid && pend_v;
        if (start) begin
          load     = 1'b1;
          tmo_n    = '0;
          rep_op   = st_instr[DATA_W-1 -: 4];
          rep_pass = !p_ill;
          rep_err  = p_ill ? ERR_ILLEGAL : ERR_NONE;
          state_n  = (p_ill || p_n == 2'd0) ? S_REPORT : S_ACC1;
        end
      end
      default: begin
        // every exit from ACCn goes through REPORT, so any new instruction waits there
        pend_v_n = instr_valid;
        pend_i_n = instr_valid ? instr : pend_i;
        tmo_n    = mem_valid ? '0 : tmo + 1'b1;
        if (mem_valid) begin
          state_n  = (acc_err != ERR_NONE || last || instr_valid) ? S_REPORT : S_ACC2;
          rep_err  = (acc_err != ERR_NONE) ? acc_err : last ? ERR_NONE : ERR_OVERLAP;
          rep_pass = acc_err == ERR_NONE && last;
        end else if (instr_valid) begin
          state_n = S_REPORT;
          rep_err = ERR_OVERLAP;
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          state_n = S_REPORT;
          rep_err = ERR_TIMEOUT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tmo        <= '0;
      pend_v     <= 1'b0;
      pend_i     <= '0;
      cur_op     <= '0;
      cur_n      <= '0;
      cur_d1     <= 1'b0;
      cur_d2     <= 1'b0;
      busy       <= 1'b0;
      chk_done   <= 1'b0;
      chk_pass   <= 1'b0;
      chk_opcode <= '0;
      err_code   <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
    end else begin
      state    <= state_n;
      tmo      <= tmo_n;
      pend_v   <= pend_v_n;
      pend_i   <= pend_i_n;
      busy     <= state_n != S_IDLE;
      chk_done <= rep;
      if (load) begin
        cur_op <= st_instr[DATA_W-1 -: 4];
        cur_n  <= p_n;
        cur_d1 <= p_d1;
        cur_d2 <= p_d2;
      end
      if (rep) begin
        chk_pass   <= rep_pass;
        err_code   <= rep_err;
        chk_opcode <= rep_op;
      end
      pass_cnt <= psum[CNT_W] ? '1 : psum[CNT_W-1:0];
      fail_cnt <= fsum[CNT_W] ? '1 : fsum[CNT_W-1:0];
    end
  end
endmodule

// File: doc/lc3_txn_checker.md
# lc3_txn_checker

Synthesizable, cycle-based instruction-transaction checker for the LC-3 datapath. It replaces the delay-driven per-opcode check with a clocked state machine. Each instruction latched into IR is decoded to an expected sequence of memory accesses. Each access is compared against golden address/data supplied by the reference model, and a per-instruction pass/fail result is reported with saturating pass/fail counters. It sits beside the CPU on the memory bus, in simulation or on FPGA.

## Interface
- `ADDR_W`, 16, memory address width
- `DATA_W`, 16, memory data width (opcode = bits [15:12])
- `TIMEOUT`, 8, max cycles allowed between consecutive expected events (≥1)
- `CNT_W`, 16, width of pass/fail counters
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `instr_valid`  in  1  one-cycle pulse: new instruction latched into IR
- `instr`  in  DATA_W  instruction word, valid with `instr_valid`
- `mem_valid`  in  1  one-cycle pulse per memory access
- `mem_we`  in  1  1 = write, 0 = read; qualified by `mem_valid`
- `mem_addr`  in  ADDR_W  access address
- `mem_wdata`  in  DATA_W  write data
- `addr_ideal`  in  ADDR_W  golden address, sampled with `mem_valid`
- `data_ideal`  in  DATA_W  golden write data, sampled with `mem_valid`
- `busy`  out  1  check in progress
- `chk_done`  out  1  one-cycle result strobe
- `chk_pass`  out  1  result, valid with `chk_done`
- `chk_opcode`  out  4  opcode of the reported instruction
- `err_code`  out  3  0 NONE, 1 ADDR, 2 DATA, 3 DIR, 4 TIMEOUT, 5 OVERLAP, 6 ILLEGAL
- `pass_cnt`, `fail_cnt`  out  CNT_W  saturating totals

## Operation
Expected access plan per opcode:
- ADD, AND, NOT, LEA, BR: no accesses.
- LD, LDR: 1 read.
- ST, STR: 1 write.
- LDI: read (pointer), then read (data).
- STI: read (pointer), then write.
- JMP/RET (1100), JSR/JSRR (0100): 1 read, which is the next fetch at the target; the address is checked only.
- RTI (1000), reserved (1101), TRAP (1111): fail with ILLEGAL immediately.

FSM states are IDLE, ACC1, ACC2, REPORT.
- IDLE + `instr_valid`:
  - zero-access or illegal opcode → REPORT.
  - otherwise → ACC1.
  - Opcode and plan are latched, and the timeout counter is cleared.
- ACCn + `mem_valid`, checks applied in priority order:
  1. direction mismatch → DIR.
  2. `mem_addr`≠`addr_ideal` → ADDR.
  3. write with `mem_wdata`≠`data_ideal` → DATA.
- Any failure → REPORT with that error. Success → next access state, or REPORT if this was the last access.
- The timeout counter increments each ACCn cycle without `mem_valid` and clears on each accepted access. Reaching TIMEOUT → REPORT, TIMEOUT.
- REPORT: one cycle, then → IDLE.
  - Pulses `chk_done` and updates exactly one counter.
  - Counters saturate at all-ones.
- `mem_valid` in IDLE or REPORT is ignored.

## Timing
- Reset, asynchronous: state IDLE, `busy`=0, `chk_done`=0, `chk_pass`=0, `chk_opcode`=0, `err_code`=0, counters=0. An in-flight check is discarded and not counted.
- All outputs are registered.
- Latency:
  - Zero-access opcode: `instr_valid` at edge N → `chk_done` high in cycle N+1.
  - Access opcode: final/failing `mem_valid` at edge M → `chk_done` in M+1.
- `busy`=1 in ACC1/ACC2/REPORT.
- `chk_pass`/`err_code`/`chk_opcode` hold after the strobe until the next report.
- Simultaneous `mem_valid` and `instr_valid` in ACCn:
  - The access is evaluated first.
  - If the access completes the check: report normally; the new instruction is latched and starts after REPORT, in cycle M+2.
  - If the access does not complete the check: report OVERLAP; the new instruction is latched.
- `instr_valid` alone in ACCn → OVERLAP report; the new instruction is latched and is checked after REPORT.
- `instr_valid` during REPORT → latched; goes to ACC1 (or REPORT for zero-access) next cycle. No instruction is lost.
- At most one pending instruction is held. A further `instr_valid` before it starts overwrites it and counts one OVERLAP fail.

## Structure
- Package `lc3_pkg`: opcode localparams (OP_ADD…OP_TRAP), err_code enum, FSM state enum.
- Sub-module `lc3_access_plan`: combinational opcode → {n_acc, dir1, dir2, illegal}.
- Counters and FSM live in the top level.

## Test plan
- ADD 0x1261 pulse → `chk_done` next cycle, `chk_pass`=1, `err_code`=0, `pass_cnt`=1.
- ST 0x3005, write to 0x3006 with data 0x00AB matching ideal → pass. Repeat with ideal data 0x00AC → fail, DATA, `fail_cnt`=1.
- LDI 0xA002: read 0x3003 then read 0x4000. Second `addr_ideal`=0x4001 → fail ADDR, reported the cycle after the second access.
- STI with first access a write → DIR. LD with no access for 8 cycles → TIMEOUT reported in cycle 9.
- LD followed by a new `instr_valid` before any access → OVERLAP. The new ADD then passes with no lost strobe. TRAP 0xF025 → ILLEGAL.
- Assert `rst_n` mid-LDI → all outputs 0 asynchronously. Force `pass_cnt` to all-ones → stays saturated after a further pass.
